// File: rtl/frame_wr_addr_gen.sv
// Write-side address generator: turns a video-timed pixel stream into
// frame-local SDRAM write strobes and flags malformed frames.
module frame_wr_addr_gen #(
  parameter int ADDR_BITS   = 21,
  parameter int DATA_BITS   = 32,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int FRAME_WORDS = 307200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_en,
  input  logic                 vs_in,
  input  logic                 de_in,
  input  logic [DATA_BITS-1:0] pix_in,
  output logic                 App_wr_en,
  output logic [ADDR_BITS-1:0] App_wr_addr,
  output logic [DATA_BITS-1:0] App_wr_din,
  output logic [3:0]           App_wr_dm,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 err_line
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(FRAME_WORDS - 1);
  localparam logic [XW-1:0]        LAST_X    = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]        LAST_Y    = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic                   vs_d_q, vs_arm_q, de_d_q;
  logic [ADDR_BITS-1:0]   word_cnt_q, word_cnt_d;
  logic [XW-1:0]          x_cnt_q, x_cnt_d;
  logic [YW-1:0]          y_cnt_q, y_cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]   wr_din_q, wr_din_d;
  logic                   done_q, done_d;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q, err_long_d;
  logic                   err_line_q, err_line_d;

  logic                   vs_rise, accept;
  logic [ADDR_BITS-1:0]   base_cnt;
  logic [XW-1:0]          base_x;
  logic [YW-1:0]          base_y;

  // vs_arm_q blocks a frame start until vs_in has been seen low after reset.
  // A vs_rise takes precedence over the old frame, so base_* are the counters
  // the accepted pixel is placed against.
  always_comb begin
    vs_rise     = vs_in & ~vs_d_q & vs_arm_q;
    accept      = de_in & (vs_rise ? cap_en : (state_q == CAPTURE));
    base_cnt    = vs_rise ? '0 : word_cnt_q;
    base_x      = vs_rise ? '0 : x_cnt_q;
    base_y      = vs_rise ? '0 : y_cnt_q;
    state_d     = state_q;
    word_cnt_d  = base_cnt;
    x_cnt_d     = base_x;
    y_cnt_d     = base_y;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_din_d    = wr_din_q;
    done_d      = 1'b0;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    err_line_d  = err_line_q;

    if (vs_rise) begin
      if (state_q == CAPTURE && word_cnt_q != '0) err_short_d = 1'b1;
      state_d = cap_en ? CAPTURE : IDLE;
    end
    if (state_q == CAPTURE && de_d_q && !de_in && x_cnt_q != '0) err_line_d = 1'b1;
    if (state_q == HOLD && de_in && !vs_rise) err_long_d = 1'b1;

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = base_cnt;
      wr_din_d  = pix_in;
      if (base_cnt == LAST_WORD) begin
        done_d     = 1'b1;
        word_cnt_d = '0;
        x_cnt_d    = '0;
        y_cnt_d    = '0;
        state_d    = HOLD;
      end else begin
        word_cnt_d = base_cnt + 1'b1;
        if (base_x == LAST_X) begin
          x_cnt_d = '0;
          y_cnt_d = (base_y == LAST_Y) ? '0 : base_y + 1'b1;
        end else begin
          x_cnt_d = base_x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vs_d_q      <= 1'b0;
      vs_arm_q    <= 1'b0;
      de_d_q      <= 1'b0;
      word_cnt_q  <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_din_q    <= '0;
      done_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_line_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_d_q      <= vs_in;
      vs_arm_q    <= vs_arm_q | ~vs_in;
      de_d_q      <= de_in;
      word_cnt_q  <= word_cnt_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_din_q    <= wr_din_d;
      done_q      <= done_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_line_q  <= err_line_d;
    end
  end

  assign App_wr_en   = wr_en_q;
  assign App_wr_addr = wr_addr_q;
  assign App_wr_din  = wr_din_q;
  assign App_wr_dm   = 4'b0000;
  assign frame_busy  = (state_q == CAPTURE);
  assign frame_done  = done_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign err_line    = err_line_q;

endmodule

// File: tb/tb_frame_wr_addr_gen.sv
// Scoreboard bench for frame_wr_addr_gen: a frame-level reference model queues
// expected writes while a monitor compares every DUT output cycle.
module tb_frame_wr_addr_gen;

  localparam int ADDR_BITS = 21;
  localparam int DATA_BITS = 32;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int FW = 12;
  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_HOLD = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cap_en = 1'b0;
  logic                 vs_in = 1'b0;
  logic                 de_in = 1'b0;
  logic [DATA_BITS-1:0] pix_in = '0;
  logic                 App_wr_en;
  logic [ADDR_BITS-1:0] App_wr_addr;
  logic [DATA_BITS-1:0] App_wr_din;
  logic [3:0]           App_wr_dm;
  logic                 frame_busy, frame_done, err_short, err_long, err_line;

  frame_wr_addr_gen #(
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
    .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .vs_in(vs_in), .de_in(de_in),
    .pix_in(pix_in), .App_wr_en(App_wr_en), .App_wr_addr(App_wr_addr),
    .App_wr_din(App_wr_din), .App_wr_dm(App_wr_dm), .frame_busy(frame_busy),
    .frame_done(frame_done), .err_short(err_short), .err_long(err_long),
    .err_line(err_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] din;
    bit          done;
    int          cyc;
  } expT;

  expT         expQ[$];
  int          total = 0;
  int          bad = 0;
  int          cycleCnt = 0;
  int          mState, mCount, mCol;
  bit          mPrevVs, mPrevDe, mArmed, mErrShort, mErrLong, mErrLine;
  int          lastAddr = 0;
  logic [31:0] lastDin = '0;
  bit          rstEdge;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Frame-level reference: what one clock edge does to the stream position.
  task automatic modelStep(input bit r, input bit v, input bit d, input logic [31:0] p, input bit c);
    bit rise, acc;
    if (r) begin
      mState = M_IDLE; mCount = 0; mCol = 0;
      mPrevVs = 0; mPrevDe = 0; mArmed = 0;
      mErrShort = 0; mErrLong = 0; mErrLine = 0;
      return;
    end
    rise = v && !mPrevVs && mArmed;
    if (mState == M_CAP && !d && mPrevDe && mCol != 0) mErrLine = 1;
    if (mState == M_HOLD && d && !rise) mErrLong = 1;
    acc = rise ? (d && c) : (d && mState == M_CAP);
    if (rise) begin
      if (mState == M_CAP && mCount != 0) mErrShort = 1;
      mCount = 0;
      mCol = 0;
      mState = c ? M_CAP : M_IDLE;
    end
    if (acc) begin
      expQ.push_back('{mCount, p, bit'(mCount == FW - 1), cycleCnt + 1});
      mCount++;
      mCol = (mCol + 1) % H;
      if (mCount == FW) begin
        mCount = 0;
        mCol = 0;
        mState = M_HOLD;
      end
    end
    mPrevVs = v;
    mPrevDe = d;
    mArmed = mArmed || !v;
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit d, input logic [31:0] p, input bit c);
    @(negedge clk);
    rst = r; vs_in = v; de_in = d; pix_in = p; cap_en = c;
    modelStep(r, v, d, p, c);
  endtask

  task automatic idle(input int n, input bit c);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, c);
  endtask

  task automatic vsPulse(input bit c, input int hi);
    for (int i = 0; i < hi; i++) applyStimulus(0, 1, 0, 32'h0, c);
  endtask

  task automatic pixels(input int n, input logic [31:0] base, input bit c);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 1, base + 32'(i), c);
      if ((i + 1) % H == 0 && i + 1 < n) idle(2, c);
    end
  endtask

  task automatic checkFlags(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, "_busy"}, 64'(frame_busy), 64'(mState == M_CAP));
    checkOutput({tag, "_errShort"}, 64'(err_short), 64'(mErrShort));
    checkOutput({tag, "_errLong"}, 64'(err_long), 64'(mErrLong));
    checkOutput({tag, "_errLine"}, 64'(err_line), 64'(mErrLine));
  endtask

  // Monitor: every write must match the head of the scoreboard on the exact
  // cycle; outside writes the address/data must hold and frame_done stay low.
  always @(posedge clk) begin
    rstEdge = rst;
    cycleCnt++;
    #1;
    if (rstEdge) begin
      checkOutput("rstWrEn", 64'(App_wr_en), 64'(0));
      checkOutput("rstAddr", 64'(App_wr_addr), 64'(0));
      checkOutput("rstDin", 64'(App_wr_din), 64'(0));
      checkOutput("rstDone", 64'(frame_done), 64'(0));
      lastAddr = 0;
      lastDin = '0;
    end else if (App_wr_en) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", 64'(App_wr_addr), 64'hFFFF_FFFF);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("wrAddr", 64'(App_wr_addr), 64'(e.addr));
        checkOutput("wrDin", 64'(App_wr_din), 64'(e.din));
        checkOutput("wrDm", 64'(App_wr_dm), 64'(0));
        checkOutput("wrDone", 64'(frame_done), 64'(e.done));
        checkOutput("wrCycle", 64'(cycleCnt), 64'(e.cyc));
        lastAddr = e.addr;
        lastDin = e.din;
      end
    end else begin
      checkOutput("idleDone", 64'(frame_done), 64'(0));
      checkOutput("holdAddr", 64'(App_wr_addr), 64'(lastAddr));
      checkOutput("holdDin", 64'(App_wr_din), 64'(lastDin));
      if (expQ.size() != 0 && expQ[0].cyc < cycleCnt)
        checkOutput("missingWrite", 64'(expQ[0].cyc), 64'(cycleCnt));
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, kind;
    bit c;
    modelStep(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h0, 0);
    checkFlags("reset");
    idle(3, 1);

    $display("[TB] normal frame");
    vsPulse(1, 1);
    idle(2, 1);
    pixels(12, 32'h100, 1);
    idle(3, 1);
    checkFlags("normal");

    $display("[TB] short frame");
    vsPulse(1, 1);
    pixels(7, 32'h200, 1);
    idle(2, 1);
    vsPulse(1, 1);
    pixels(12, 32'h300, 1);
    idle(3, 1);
    checkFlags("short");

    $display("[TB] long frame");
    vsPulse(1, 1);
    pixels(12, 32'h400, 1);
    idle(1, 1);
    pixels(2, 32'h500, 1);
    idle(2, 1);
    checkFlags("long");
    vsPulse(1, 1);
    pixels(12, 32'h600, 1);
    idle(2, 1);

    $display("[TB] capture disabled");
    vsPulse(0, 1);
    pixels(6, 32'h700, 0);
    pixels(6, 32'h710, 1);
    idle(2, 1);
    checkFlags("capOff");
    vsPulse(1, 1);
    pixels(12, 32'h800, 1);
    idle(2, 1);

    $display("[TB] vs_rise with pixel in HOLD");
    applyStimulus(0, 1, 1, 32'hAA, 1);
    for (int i = 1; i < FW; i++) applyStimulus(0, 0, 1, 32'hAA + 32'(i), 1);
    idle(2, 1);
    checkFlags("vsPix");

    $display("[TB] reset mid-frame, err_line");
    vsPulse(1, 1);
    pixels(5, 32'h900, 1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 1, 32'h950, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 32'h960 + 32'(i), 1);
    checkFlags("rstHigh");
    idle(2, 1);
    vsPulse(1, 1);
    pixels(2, 32'hA00, 1);
    idle(2, 1);
    checkFlags("lineErr");
    checkOutput("errLineSet", 64'(err_line), 64'(1));

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++) begin
      c = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        applyStimulus(1, 0, 0, 32'h0, c);
        applyStimulus(1, 0, 0, 32'h0, c);
      end
      vsPulse(c, $urandom_range(1, 3));
      idle($urandom_range(0, 2), c);
      kind = $urandom_range(0, 2);
      n = (kind == 0) ? FW : (kind == 1) ? $urandom_range(1, FW - 1) : FW + $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) idle(1, c);
        if ($urandom_range(0, 9) == 0) c = ~c;
        applyStimulus(0, 0, 1, $urandom, c);
      end
      idle($urandom_range(1, 3), c);
      checkFlags("rand");
    end

    idle(5, 0);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_wr_addr_gen.md
Name: frame_wr_addr_gen

Overview:
- Upstream write-side stage for one project port of the SDRAM arbiter.
- Converts a video-timed pixel stream (vs_in / de_in / pix_in) into App_wr_en / App_wr_addr / App_wr_din / App_wr_dm strobes.
- Addresses are project-local: 0..FRAME_WORDS-1. The arbiter adds the project offset.
- Tracks frame start, pixel position and completion, and flags malformed frames.

Parameters:
ADDR_BITS, 21, width of App_wr_addr
DATA_BITS, 32, width of pix_in / App_wr_din
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
FRAME_WORDS, 307200, words per frame; must equal H_ACTIVE*V_ACTIVE and be < 2^ADDR_BITS

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
cap_en  in  1  capture enable, sampled only at a vs_in rising edge
vs_in  in  1  frame sync; a rising edge marks frame start
de_in  in  1  pixel valid
pix_in  in  DATA_BITS  pixel word, qualified by de_in
App_wr_en  out  1  one-cycle write strobe per pixel
App_wr_addr  out  ADDR_BITS  word address, 0-based within the frame
App_wr_din  out  DATA_BITS  write data
App_wr_dm  out  4  byte mask; always 4'b0000 (all bytes written)
frame_busy  out  1  high while in CAPTURE
frame_done  out  1  one-cycle pulse when word FRAME_WORDS-1 is written
err_short  out  1  sticky: new frame started before the previous one completed
err_long  out  1  sticky: de_in seen after the frame was complete
err_line  out  1  sticky: de_in fell mid-line (x_cnt != 0)

Behaviour:
- Reset: state = IDLE; vs_d, word_cnt, x_cnt, y_cnt = 0; all outputs = 0.
- vs_rise = vs_in & ~vs_d, with vs_d registered every cycle. If vs_in is high when reset is released, no frame starts until vs_in falls and rises again.
- FSM states:
  - IDLE: de_in ignored; no writes.
  - CAPTURE: active frame capture.
  - HOLD: frame complete, waiting for the next vs_rise.
- Transitions:
  - IDLE -> CAPTURE on vs_rise & cap_en.
  - CAPTURE -> HOLD after the write of word FRAME_WORDS-1.
  - HOLD -> CAPTURE on vs_rise & cap_en.
  - HOLD -> IDLE on vs_rise & ~cap_en.
  - CAPTURE, vs_rise with word_cnt != 0: set err_short; counters clear to 0; stay in CAPTURE if cap_en, else go to IDLE. No frame_done.
- Any vs_rise clears word_cnt, x_cnt and y_cnt.
- Pixel accept:
  - Condition: de_in high in the same cycle that either (a) the state is CAPTURE, or (b) vs_rise & cap_en occurs. In case (b) the pixel is word 0 of the new frame; vs_rise takes precedence over the old frame.
  - Write timing: exactly 1-cycle latency. On the next cycle App_wr_en = 1, App_wr_addr = word_cnt before increment (or 0 in case b), App_wr_din = pix_in.
  - App_wr_en is low in all other cycles. App_wr_addr and App_wr_din hold their last value when App_wr_en is low.
- Counters:
  - word_cnt increments per accepted pixel; never exceeds FRAME_WORDS-1.
  - x_cnt wraps at H_ACTIVE-1 -> 0, and y_cnt increments on that wrap.
  - frame_done is asserted in the same cycle as the App_wr_en for address FRAME_WORDS-1.
- Errors:
  - de_in high in HOLD sets err_long; the pixel is dropped.
  - A de_in falling edge in CAPTURE with x_cnt != 0 sets err_line; counters are not altered.
  - err_* flags clear only on rst.
- Reset mid-frame: the same-cycle synchronous clear wins. No further writes occur and the next frame waits for a fresh vs_rise.
- frame_busy = (state == CAPTURE).
- Arithmetic is unsigned. word_cnt is ADDR_BITS wide; x_cnt and y_cnt use $clog2 of H_ACTIVE and V_ACTIVE respectively.

Test Plan:
(bench params H_ACTIVE=4, V_ACTIVE=3, FRAME_WORDS=12)
1. Normal frame: rst, cap_en=1, vs pulse, then 3 lines of 4 de cycles with pix=0x100+i -> 12 App_wr_en pulses; addr 0..11, din 0x100..0x10B, dm=0, each 1 cycle after de. frame_done pulses with addr 11; then HOLD, frame_busy=0.
2. Short frame: vs pulse, 7 pixels, vs pulse, 12 pixels -> err_short=1. Second frame writes addr 0..11, no frame_done after the first 7. frame_done pulses once, with addr 11.
3. Long frame: complete frame, then 2 extra de cycles before the next vs -> no extra writes, err_long=1. The next vs with cap_en=1 restarts writing at addr 0.
4. Capture disabled: cap_en=0 at vs rise, 12 de cycles -> no App_wr_en. Set cap_en=1 mid-frame -> still no writes until the next vs rise.
5. Simultaneous vs_rise and de with pix=0xAA in HOLD -> App_wr_en next cycle with addr 0, din 0xAA. Following pixels go to addr 1, 2, ...
6. Reset mid-frame after 5 writes, vs_in held high across reset -> outputs 0, no writes until vs falls and rises. err_line: a 2-pixel line then de falls -> err_line=1.
